bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter sitting between the binary counter and the seven-segment display driver. It accepts a binary value over a valid/ready handshake and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It then presents packed BCD digits plus a leading-zero blank mask, so the display stage shows decimal instead of hex.

## Interface
- `IN_W`, default 8: width of the binary input.
- `DIGITS`, default 3: number of BCD digits produced.
  - Must satisfy 10^DIGITS > 2^IN_W − 1.
  - Elaboration error otherwise.
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: `in_data` is offered.
- `in_ready` out 1: block can accept. High only in IDLE.
- `in_data` in IN_W: unsigned binary value.
- `bcd` out 4*DIGITS: result. Digit k occupies bits [4k+3:4k], with digit 0 as the units digit. Held until the next result.
- `blank` out DIGITS: bit k = 1 when digit k is a leading zero. Bit 0 is always 0.
- `bcd_valid` out 1: one-cycle pulse marking a new `bcd`/`blank`.
- `busy` out 1: high in SHIFT and DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: capture `in_data` into the binary shift register, clear the BCD scratch register, load the iteration counter with IN_W, then go to SHIFT.
- **SHIFT**, one iteration per cycle:
  - Every scratch nibble ≥5 gets +3, all nibbles in parallel.
  - Then shift {scratch, binary} left by 1.
  - Decrement the counter. After the IN_W-th iteration, go to DONE.
- **DONE**
  - `bcd` ← scratch.
  - `blank` ← leading-zero mask: bit k set iff digits k..DIGITS−1 are all zero and k>0.
  - `bcd_valid` ← 1, then go to IDLE.
- Width rules:
  - Scratch is 4*DIGITS bits; the counter is clog2(IN_W+1) bits.
  - No nibble exceeds 9 after the final shift.
- `in_valid` while not IDLE:
  - Ignored, because `in_ready`=0.
  - The upstream holds its data; nothing is lost or queued.
- `bcd`/`blank` are unchanged during a conversion; the display never sees partial values.
- Reset values:
  - state IDLE, `in_ready`=1.
  - `bcd`=0, `blank`={DIGITS−1 ones, 0}, so the display shows "0".
  - `bcd_valid`=0, `busy`=0.
  - Scratch, shift register and counter are all 0.
- Reset mid-conversion:
  - Aborts on the next edge and all outputs take their reset values.
  - No `bcd_valid` pulse is emitted for the aborted value.

## Timing
- Edge E0: accept, when IDLE and `in_valid`.
- Edges E1..E(IN_W): shift iterations.
- Edge E(IN_W+1): result registered. `bcd_valid`=1 and `in_ready`=1 during the following cycle.
- Latency: accept edge to `bcd_valid` high = IN_W+1 edges (9 for the default).
- Throughput: with `in_valid` held high, accepts occur every IN_W+2 cycles (10 for the default).
- `bcd_valid` is registered, never high for two consecutive cycles.
- `in_ready` is decoded combinationally from state only, with no path from `in_valid`.

## Structure
- Shared package: state enum (IDLE/SHIFT/DONE), and a constant function checking DIGITS against IN_W.
- One natural sub-module: `bcd_dabble_step`.
  - Combinational.
  - Takes {scratch, binary}, applies add-3 per nibble, returns the left-shifted vector.
  - Parameterized by IN_W and DIGITS.
- The top holds the FSM, the counter, and the output registers.

## Test plan
- After reset with no input: `bcd`=0x000, `blank`=3'b110, `in_ready`=1, `bcd_valid`=0.
- Single conversions, one pulse each:
  - 8'd255 → `bcd`=0x255, `blank`=3'b000.
  - 8'd42 → `bcd`=0x042, `blank`=3'b100.
  - 8'd7 → `bcd`=0x007, `blank`=3'b110.
  - 8'd100 → `bcd`=0x100, `blank`=3'b000.
  - 8'd0 → `bcd`=0x000, `blank`=3'b110.
  - Each pulse comes exactly 9 edges after acceptance.
- Back-to-back:
  - Hold `in_valid`=1 with data 10 then 20.
  - Accepts are 10 cycles apart; results 0x010 then 0x020.
  - `in_ready` stays low while busy, and changing `in_data` mid-conversion has no effect.
- Reset asserted at iteration 4 of converting 8'd200:
  - Next cycle shows reset values and no `bcd_valid` pulse.
  - A following conversion of 8'd99 yields 0x099.
- Exhaustive sweep of 0..255 against a reference model: every result correct, no nibble >9.
- Parameter variant IN_W=14, DIGITS=5:
  - 14'd9999 → `bcd`=0x09999, `blank`=5'b10000.
  - Latency 15 edges.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // True when DIGITS decimal digits can hold the largest IN_W-bit value.
    function automatic bit digits_ok(input int unsigned in_w, input int unsigned digits);
        longint unsigned pow10;
        longint unsigned maxv;
        pow10 = 64'd1;
        maxv  = (64'd1 << in_w) - 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            pow10 = pow10 * 64'd10;
            if (pow10 > maxv) return 1'b1;
        end
        return pow10 > maxv;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_dabble_step.sv
// One double-dabble iteration: add 3 to every scratch nibble >= 5, then shift {scratch, binary} left.
module bcd_dabble_step #(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic [4*DIGITS+IN_W-1:0] vec_in,
    output logic [4*DIGITS+IN_W-1:0] vec_out
);

    localparam int unsigned VEC_W = 4 * DIGITS + IN_W;

    logic [VEC_W-1:0] adj;

    always_comb begin
        adj = vec_in;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (vec_in[IN_W + 4*k +: 4] >= 4'd5) begin
                adj[IN_W + 4*k +: 4] = vec_in[IN_W + 4*k +: 4] + 4'd3;
            end
        end
        vec_out = {adj[VEC_W-2:0], 1'b0};
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: valid/ready input, one double-dabble bit per clock,
// registered BCD digits plus leading-zero blank mask for the display driver.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  bcd_valid,
    output logic                  busy
);

    localparam int unsigned SCR_W = 4 * DIGITS;
    localparam int unsigned VEC_W = SCR_W + IN_W;
    localparam int unsigned CNT_W = $clog2(IN_W + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    if (!digits_ok(IN_W, DIGITS)) begin : g_bad_params
        $error("bin_to_bcd_seq: DIGITS too small for IN_W");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [VEC_W-1:0]   vec_step;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic               bcd_valid_q, bcd_valid_d;
    logic [DIGITS-1:0]  blank_mask;
    logic               all_zero;

    bcd_dabble_step #(
        .IN_W   (IN_W),
        .DIGITS (DIGITS)
    ) u_step (
        .vec_in  (vec_q),
        .vec_out (vec_step)
    );

    // Leading-zero mask of the finished scratch value; the units digit is never blanked.
    always_comb begin
        blank_mask = '0;
        all_zero   = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            all_zero      = all_zero & (vec_q[IN_W + 4*k +: 4] == 4'd0);
            blank_mask[k] = all_zero;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_d       = vec_q;
        bcd_d       = bcd_q;
        blank_d     = blank_q;
        bcd_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    vec_d   = {SCR_W'(0), in_data};
                    cnt_d   = CNT_W'(IN_W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                vec_d = vec_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                bcd_d       = vec_q[VEC_W-1 -: SCR_W];
                blank_d     = blank_mask;
                bcd_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            vec_q       <= '0;
            bcd_q       <= '0;
            blank_q     <= BLANK_RST;
            bcd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_q       <= vec_d;
            bcd_q       <= bcd_d;
            blank_q     <= blank_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    // Handshake status decodes from state alone so in_valid never reaches in_ready.
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign bcd       = bcd_q;
    assign blank     = blank_q;
    assign bcd_valid = bcd_valid_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus queues expected results, a monitor checks each pulse.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [11:0] bcd;
    logic [2:0]  blank;
    logic        bcd_valid;
    logic        busy;

    logic        in_valid2;
    logic        in_ready2;
    logic [13:0] in_data2;
    logic [19:0] bcd2;
    logic [4:0]  blank2;
    logic        bcd_valid2;
    logic        busy2;

    always #5 clk = ~clk;

    bin_to_bcd_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bcd       (bcd),
        .blank     (blank),
        .bcd_valid (bcd_valid),
        .busy      (busy)
    );

    bin_to_bcd_seq #(.IN_W(14), .DIGITS(5)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .bcd       (bcd2),
        .blank     (blank2),
        .bcd_valid (bcd_valid2),
        .busy      (busy2)
    );

    typedef struct {
        logic [11:0] bcd;
        logic [2:0]  blank;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   acc_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_v = 1'b0;
    exp_t me;
    int   ma;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Accept detector: records the edge index of every handshake.
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) begin
            acc_q.push_back(cyc);
            acc_log.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    // Monitor: pops the scoreboard on each result pulse.
    always @(negedge clk) begin
        if (bcd_valid) begin
            chk("no_double_pulse", 32'(prev_v), 32'd0);
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=%0h required=none", bcd);
            end else begin
                me = exp_q.pop_front();
                ma = acc_q.pop_front();
                chk("bcd", 32'(bcd), 32'(me.bcd));
                chk("blank", 32'(blank), 32'(me.blank));
                chk("latency", 32'((cyc - 1) - ma), 32'd9);
                for (int k = 0; k < 3; k++) chk("nibble_le9", 32'(bcd[4*k +: 4] <= 4'd9), 32'd1);
            end
        end
        prev_v = bcd_valid;
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic [11:0] eb, input logic [2:0] ek);
        wait_ready();
        exp_q.push_back('{eb, ek});
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hAA;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_accepts(input int target);
        int n = 0;
        while (acc_log.size() < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (acc_log.size() < target) chk("accept_timeout", 32'(acc_log.size()), 32'(target));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bad;
        int n;
        logic [3:0] h, t, u;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_valid2 = 1'b0;
        in_data2  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_bcd", 32'(bcd), 32'h000);
        chk("rst_blank", 32'(blank), 32'b110);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_bcd_valid", 32'(bcd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        send(8'd255, 12'h255, 3'b000);
        send(8'd42,  12'h042, 3'b100);
        send(8'd7,   12'h007, 3'b110);
        send(8'd100, 12'h100, 3'b000);
        send(8'd0,   12'h000, 3'b110);
        drain();

        // Back-to-back with in_valid held; data changes while the first conversion runs.
        wait_ready();
        base = acc_log.size();
        exp_q.push_back('{12'h010, 3'b100});
        exp_q.push_back('{12'h020, 3'b100});
        in_valid = 1'b1;
        in_data  = 8'd10;
        wait_accepts(base + 1);
        in_data = 8'd20;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
            if (i < 8) @(negedge clk);
        end
        chk("ready_low_while_busy", 32'(bad), 32'd0);
        wait_accepts(base + 2);
        in_valid = 1'b0;
        in_data  = 8'hAA;
        if (acc_log.size() >= base + 2)
            chk("accept_spacing", 32'(acc_log[base+1] - acc_log[base]), 32'd10);
        drain();

        // Reset during the fourth iteration of 200.
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'd200;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_bcd", 32'(bcd), 32'h000);
        chk("abort_blank", 32'(blank), 32'b110);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bcd_valid", 32'(bcd_valid), 32'd0);
        rst = 1'b0;
        if (acc_q.size() != 0) void'(acc_q.pop_back());
        repeat (12) @(negedge clk);
        send(8'd99, 12'h099, 3'b100);
        drain();

        // Sweep against a decimal reference.
        for (int v = 0; v < 256; v++) begin
            h = 4'(v / 100);
            t = 4'((v / 10) % 10);
            u = 4'(v % 10);
            send(8'(v), {h, t, u}, {(h == 4'd0), (h == 4'd0) && (t == 4'd0), 1'b0});
        end
        drain();

        // Wide variant.
        n = 0;
        while (!in_ready2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid2 = 1'b1;
        in_data2  = 14'd9999;
        n = 0;
        do begin
            @(negedge clk);
            in_valid2 = 1'b0;
            n++;
        end while (!bcd_valid2 && n < 40);
        chk("w_latency", 32'(n - 1), 32'd15);
        chk("w_bcd", 32'(bcd2), 32'h09999);
        chk("w_blank", 32'(blank2), 32'b10000);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
